// File: rtl/my_pipelined_shifter.sv
// Three-stage pipelined 32-bit shifter (SLL/SRL/SRA/pass) with per-stage valid/ready
// handshaking, bubble collapsing and a synchronous flush for branch mispredicts.
module my_pipelined_shifter (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] data_in,
    input  logic [4:0]  shamt,
    input  logic [1:0]  op,
    input  logic [4:0]  tag_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] data_out,
    output logic [4:0]  tag_out,
    output logic        busy
);

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;

    // One conditional sub-shift; SRA fills from the sign captured at accept.
    function automatic logic [31:0] f_sub_shift(
        input logic [31:0] d,
        input logic        en,
        input logic [4:0]  k,
        input logic [1:0]  o,
        input logic        sign
    );
        logic [31:0] r;
        r = d;
        if (en) begin
            case (o)
                OP_SLL:  r = d << k;
                OP_SRL:  r = d >> k;
                OP_SRA:  r = (d >> k) | (~(32'hFFFF_FFFF >> k) & {32{sign}});
                default: r = d;
            endcase
        end else begin
            r = d;
        end
        return r;
    endfunction

    logic        r_s1_valid;
    logic [31:0] r_s1_data;
    logic [2:0]  r_s1_shamt;
    logic [1:0]  r_s1_op;
    logic [4:0]  r_s1_tag;
    logic        r_s1_sign;

    logic        r_s2_valid;
    logic [31:0] r_s2_data;
    logic        r_s2_sh0;
    logic [1:0]  r_s2_op;
    logic [4:0]  r_s2_tag;
    logic        r_s2_sign;

    logic        r_s3_valid;
    logic [31:0] r_s3_data;
    logic [4:0]  r_s3_tag;

    logic        w_s3_open;
    logic        w_s2_open;
    logic        w_s1_open;
    logic        w_in_fire;
    logic        w_s1_move;
    logic        w_s2_move;
    logic [31:0] w_s1_data;
    logic [31:0] w_s2_data;
    logic [31:0] w_s3_data;

    // A stage is open when empty or when its occupant leaves this same cycle.
    assign w_s3_open = !r_s3_valid || out_ready;
    assign w_s2_open = !r_s2_valid || w_s3_open;
    assign w_s1_open = !r_s1_valid || w_s2_open;
    assign in_ready  = !flush && w_s1_open;
    assign w_in_fire = in_valid && in_ready;
    assign w_s1_move = r_s1_valid && w_s2_open && !flush;
    assign w_s2_move = r_s2_valid && w_s3_open && !flush;

    assign w_s1_data = f_sub_shift(f_sub_shift(data_in, shamt[4], 5'd16, op, data_in[31]),
                                   shamt[3], 5'd8, op, data_in[31]);
    assign w_s2_data = f_sub_shift(f_sub_shift(r_s1_data, r_s1_shamt[2], 5'd4, r_s1_op, r_s1_sign),
                                   r_s1_shamt[1], 5'd2, r_s1_op, r_s1_sign);
    assign w_s3_data = f_sub_shift(r_s2_data, r_s2_sh0, 5'd1, r_s2_op, r_s2_sign);

    // Valid bits for all three stages; flush empties the pipe.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s3_valid <= 1'b0;
        end else if (flush) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s3_valid <= 1'b0;
        end else begin
            if (w_s1_open) begin
                r_s1_valid <= w_in_fire;
            end
            if (w_s2_open) begin
                r_s2_valid <= r_s1_valid;
            end
            if (w_s3_open) begin
                r_s3_valid <= r_s2_valid;
            end
        end
    end

    // Stage 1 payload: 16/8-bit shifts plus captured controls.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_data  <= 32'h0;
            r_s1_shamt <= 3'd0;
            r_s1_op    <= 2'b00;
            r_s1_tag   <= 5'd0;
            r_s1_sign  <= 1'b0;
        end else if (w_in_fire) begin
            r_s1_data  <= w_s1_data;
            r_s1_shamt <= shamt[2:0];
            r_s1_op    <= op;
            r_s1_tag   <= tag_in;
            r_s1_sign  <= data_in[31];
        end
    end

    // Stage 2 payload: 4/2-bit shifts.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_s2_data <= 32'h0;
            r_s2_sh0  <= 1'b0;
            r_s2_op   <= 2'b00;
            r_s2_tag  <= 5'd0;
            r_s2_sign <= 1'b0;
        end else if (w_s1_move) begin
            r_s2_data <= w_s2_data;
            r_s2_sh0  <= r_s1_shamt[0];
            r_s2_op   <= r_s1_op;
            r_s2_tag  <= r_s1_tag;
            r_s2_sign <= r_s1_sign;
        end
    end

    // Stage 3 output register: final 1-bit shift.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_s3_data <= 32'h0;
            r_s3_tag  <= 5'd0;
        end else if (w_s2_move) begin
            r_s3_data <= w_s3_data;
            r_s3_tag  <= r_s2_tag;
        end
    end

    assign out_valid = r_s3_valid;
    assign data_out  = r_s3_data;
    assign tag_out   = r_s3_tag;
    assign busy      = r_s1_valid | r_s2_valid | r_s3_valid;

endmodule

// File: tb/tb_my_pipelined_shifter.sv
// Scoreboard bench for my_pipelined_shifter: stimulus pushes hand-computed results,
// a negedge monitor pops and compares every output transfer.
module tb_my_pipelined_shifter;

    logic        clock;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] data_in;
    logic [4:0]  shamt;
    logic [1:0]  op;
    logic [4:0]  tag_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] data_out;
    logic [4:0]  tag_out;
    logic        busy;

    typedef struct {
        logic [31:0] d;
        logic [4:0]  t;
        int          c;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    my_pipelined_shifter dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .shamt     (shamt),
        .op        (op),
        .tag_in    (tag_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .tag_out   (tag_out),
        .busy      (busy)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every output transfer must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (reset_n && !flush && out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("stale_output", {27'd0, tag_out}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk($sformatf("t%0d_data", e.t), data_out, e.d);
                chk($sformatf("t%0d_tag", e.t), {27'd0, tag_out}, {27'd0, e.t});
                if (e.c >= 0) begin
                    chk($sformatf("t%0d_latency", e.t), 32'(cyc), 32'(e.c));
                end
            end
        end
    end

    task automatic issue(input logic [31:0] d, input logic [4:0] s, input logic [1:0] o,
                         input logic [4:0] t, input logic [31:0] exp, input bit timed);
        int waited;
        exp_t e;
        waited   = 0;
        in_valid = 1'b1;
        data_in  = d;
        shamt    = s;
        op       = o;
        tag_in   = t;
        while (1) begin
            @(negedge clock);
            if (in_ready) begin
                e.d = exp;
                e.t = t;
                e.c = timed ? cyc + 3 : -1;
                q.push_back(e);
                @(posedge clock);
                #1;
                in_valid = 1'b0;
                break;
            end
            waited++;
            if (waited > 50) begin
                chk($sformatf("t%0d_accept_timeout", t), 32'(waited), 32'd0);
                in_valid = 1'b0;
                break;
            end
            @(posedge clock);
            #1;
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (q.size() != 0 && n < 40) begin
            @(posedge clock);
            n++;
        end
        #1;
        chk({"drain_", name}, 32'(q.size()), 32'd0);
        repeat (2) @(posedge clock);
        #1;
    endtask

    initial begin
        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        data_in   = 32'h0;
        shamt     = 5'd0;
        op        = 2'b00;
        tag_in    = 5'd0;
        out_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_data_out", data_out, 32'h0);
        chk("rst_tag_out", {27'd0, tag_out}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Directed single operations.
        issue(32'h0000_0001, 5'd31, 2'b00, 5'd7,  32'h8000_0000, 1'b1);
        issue(32'h0000_0001, 5'd0,  2'b00, 5'd8,  32'h0000_0001, 1'b1);
        issue(32'h8000_0000, 5'd4,  2'b01, 5'd10, 32'h0800_0000, 1'b1);
        issue(32'h8000_0000, 5'd4,  2'b10, 5'd11, 32'hF800_0000, 1'b1);
        issue(32'h7FFF_FFFF, 5'd31, 2'b10, 5'd12, 32'h0000_0000, 1'b1);
        issue(32'h8000_0000, 5'd31, 2'b10, 5'd13, 32'hFFFF_FFFF, 1'b1);
        issue(32'hFFFF_FFFF, 5'd31, 2'b01, 5'd14, 32'h0000_0001, 1'b1);
        issue(32'h0000_00FF, 5'd8,  2'b00, 5'd15, 32'h0000_FF00, 1'b1);
        issue(32'h8765_4321, 5'd12, 2'b10, 5'd16, 32'hFFF8_7654, 1'b1);
        issue(32'h1234_5678, 5'd5,  2'b11, 5'd17, 32'h1234_5678, 1'b1);
        drain("directed");

        // Five back-to-back operations.
        for (int i = 1; i <= 5; i++) begin
            issue(32'h0000_0001, 5'(i), 2'b00, 5'(i), 32'h0000_0001 << i, 1'b1);
        end
        drain("stream");

        // Backpressure: three entries fill the pipe, the fourth waits.
        out_ready = 1'b0;
        issue(32'hF000_0000, 5'd4, 2'b01, 5'd1, 32'h0F00_0000, 1'b0);
        issue(32'h0000_0003, 5'd1, 2'b00, 5'd2, 32'h0000_0006, 1'b0);
        issue(32'hC000_0000, 5'd1, 2'b10, 5'd3, 32'hE000_0000, 1'b0);
        in_valid = 1'b1;
        data_in  = 32'hCAFE_F00D;
        shamt    = 5'd9;
        op       = 2'b11;
        tag_in   = 5'd4;
        repeat (2) begin
            @(negedge clock);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_busy", {31'd0, busy}, 32'd1);
            @(posedge clock);
            #1;
        end
        out_ready = 1'b1;
        issue(32'hCAFE_F00D, 5'd9, 2'b11, 5'd4, 32'hCAFE_F00D, 1'b0);
        drain("backpressure");

        // Flush with two entries in flight and an input presented.
        issue(32'h0000_0010, 5'd1, 2'b00, 5'd20, 32'h0000_0020, 1'b1);
        issue(32'h0000_0010, 5'd2, 2'b00, 5'd21, 32'h0000_0040, 1'b1);
        flush    = 1'b1;
        in_valid = 1'b1;
        data_in  = 32'h5555_5555;
        tag_in   = 5'd22;
        @(negedge clock);
        chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
        q.delete();
        @(posedge clock);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_busy", {31'd0, busy}, 32'd0);
        chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
        repeat (6) @(posedge clock);
        #1;

        // Asynchronous reset mid-stream.
        issue(32'h0000_0001, 5'd3, 2'b00, 5'd25, 32'h0000_0008, 1'b1);
        issue(32'h0000_0001, 5'd4, 2'b00, 5'd26, 32'h0000_0010, 1'b1);
        issue(32'h0000_0001, 5'd5, 2'b00, 5'd27, 32'h0000_0020, 1'b1);
        chk("pre_rst_out_valid", {31'd0, out_valid}, 32'd1);
        #2;
        reset_n = 1'b0;
        q.delete();
        #1;
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_data_out", data_out, 32'h0);
        chk("mid_rst_tag_out", {27'd0, tag_out}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        issue(32'hDEAD_BEEF, 5'd7, 2'b11, 5'd9, 32'hDEAD_BEEF, 1'b1);
        drain("after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
